// File: rtl/pueo_scaler_pkg.sv
// Shared types and constants for the scaler readout sequencer.
package pueo_scaler_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  // Default number of cycles to wait for a bank acknowledge
  localparam int TIMEOUT_DEFAULT = 15;

  // Result word written when a channel never answers; sliced to CNT_BITS
  localparam logic [63:0] RESULT_ONES = '1;

  // Result RAM address width: {bank, channel}
  function automatic int addr_width(input int nchan);
    return $clog2(nchan) + 1;
  endfunction

endpackage

// File: rtl/pueo_scaler_tick_gen.sv
// Readout tick source: PPS pulse or free-running period counter, registered.
module pueo_scaler_tick_gen (
  input  logic        sysclk_i,
  input  logic        sysclk_rstn_i,
  input  logic        use_pps_i,
  input  logic        pps_i,
  input  logic [31:0] period_i,
  output logic        tick_o
);

  logic [31:0] cnt_q, cnt_d;
  logic        tick_q, tick_d;
  logic        int_tick;

  // Period counter wraps only on compare-equal, so a new period applies at the next wrap
  always_comb begin
    cnt_d    = cnt_q + 32'd1;
    int_tick = 1'b0;
    if (period_i == 32'd0) begin
      cnt_d = '0;
    end else if (cnt_q == period_i - 32'd1) begin
      cnt_d    = '0;
      int_tick = 1'b1;
    end
    tick_d = use_pps_i ? pps_i : int_tick;
  end

  // Counter and registered tick
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/pueo_scaler_readout_seq.sv
// Periodic read-and-clear of every scaler channel into a double-buffered result RAM.
module pueo_scaler_readout_seq
  import pueo_scaler_pkg::*;
#(
  parameter int NCHAN    = 32,
  parameter int CNT_BITS = 16,
  parameter int TIMEOUT  = TIMEOUT_DEFAULT,
  localparam int CW      = $clog2(NCHAN),
  localparam int AW      = addr_width(NCHAN),
  localparam int TW      = $clog2(TIMEOUT + 1)
) (
  input  logic                sysclk_i,
  input  logic                sysclk_rstn_i,
  input  logic                enable_i,
  input  logic                use_pps_i,
  input  logic                pps_i,
  input  logic [31:0]         period_i,
  input  logic [NCHAN-1:0]    chan_en_i,
  output logic                scal_req_o,
  output logic [CW-1:0]       scal_chan_o,
  input  logic                scal_ack_i,
  input  logic [CNT_BITS-1:0] scal_dat_i,
  output logic                buf_we_o,
  output logic [AW-1:0]       buf_addr_o,
  output logic [CNT_BITS-1:0] buf_dat_o,
  output logic                bank_o,
  output logic                done_o,
  output logic                busy_o,
  output logic                overrun_o,
  output logic                timeout_o,
  input  logic                clr_flags_i
);

  state_e              state_q, state_d;
  logic [CW-1:0]       chan_q, chan_d;
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic [CNT_BITS-1:0] data_q, data_d;
  logic                bank_q, bank_d;
  logic                ovr_q, ovr_d;
  logic                tmo_q, tmo_d;
  logic                tick;
  logic                ovr_set, tmo_set;

  pueo_scaler_tick_gen u_tick (
    .sysclk_i      (sysclk_i),
    .sysclk_rstn_i (sysclk_rstn_i),
    .use_pps_i     (use_pps_i),
    .pps_i         (pps_i),
    .period_i      (period_i),
    .tick_o        (tick)
  );

  // Sequencer next-state: walk all channels, then publish the set by flipping the bank
  always_comb begin
    state_d = state_q;
    chan_d  = chan_q;
    wcnt_d  = wcnt_q;
    data_d  = data_q;
    bank_d  = bank_q;
    tmo_set = 1'b0;
    // A tick is only consumed in IDLE; anywhere else (DONE included) it is an overrun
    ovr_set = tick && (state_q != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        if (tick && enable_i) begin
          chan_d  = '0;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!chan_en_i[chan_q]) begin
          data_d  = '0;
          state_d = ST_WRITE;
        end else begin
          wcnt_d  = '0;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (scal_ack_i) begin
          data_d  = scal_dat_i;
          state_d = ST_WRITE;
        end else if (wcnt_q == TW'(TIMEOUT - 1)) begin
          data_d  = RESULT_ONES[CNT_BITS-1:0];
          tmo_set = 1'b1;
          state_d = ST_WRITE;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      ST_WRITE: begin
        if (chan_q == CW'(NCHAN - 1)) begin
          state_d = ST_DONE;
        end else begin
          chan_d  = chan_q + 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_DONE: begin
        bank_d  = ~bank_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Sticky flags: a same-cycle set event beats a software clear
    ovr_d = ovr_set ? 1'b1 : (clr_flags_i ? 1'b0 : ovr_q);
    tmo_d = tmo_set ? 1'b1 : (clr_flags_i ? 1'b0 : tmo_q);
  end

  // Control state with asynchronous reset
  always_ff @(posedge sysclk_i or negedge sysclk_rstn_i) begin
    if (!sysclk_rstn_i) begin
      state_q <= ST_IDLE;
      chan_q  <= '0;
      wcnt_q  <= '0;
      bank_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      chan_q  <= chan_d;
      wcnt_q  <= wcnt_d;
      bank_q  <= bank_d;
      ovr_q   <= ovr_d;
      tmo_q   <= tmo_d;
    end
  end

  // Result word holding register; only observed while writing, so it needs no reset
  always_ff @(posedge sysclk_i) begin
    data_q <= data_d;
  end

  // Outputs decode from registered state so reset clears them immediately
  assign scal_req_o  = ((state_q == ST_REQ) && chan_en_i[chan_q]) || (state_q == ST_WAIT);
  assign scal_chan_o = chan_q;
  assign buf_we_o    = (state_q == ST_WRITE);
  assign buf_addr_o  = buf_we_o ? {~bank_q, chan_q} : '0;
  assign buf_dat_o   = buf_we_o ? data_q : '0;
  assign bank_o      = bank_q;
  assign done_o      = (state_q == ST_DONE);
  assign busy_o      = (state_q != ST_IDLE);
  assign overrun_o   = ovr_q;
  assign timeout_o   = tmo_q;

endmodule

// File: tb/tb_pueo_scaler_readout_seq.sv
// Self-checking bench for the scaler readout sequencer (NCHAN=4).
module tb_pueo_scaler_readout_seq;

  localparam int NCH = 4;
  localparam int CB  = 16;
  localparam int TMO = 15;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enable_i = 1'b0;
  logic        use_pps_i = 1'b1;
  logic        pps_i = 1'b0;
  logic [31:0] period_i = '0;
  logic [3:0]  chan_en_i = '0;
  logic        scal_req_o;
  logic [1:0]  scal_chan_o;
  logic        scal_ack_i = 1'b0;
  logic [15:0] scal_dat_i = '0;
  logic        buf_we_o;
  logic [2:0]  buf_addr_o;
  logic [15:0] buf_dat_o;
  logic        bank_o, done_o, busy_o, overrun_o, timeout_o;
  logic        clr_flags_i = 1'b0;

  pueo_scaler_readout_seq #(.NCHAN(NCH), .CNT_BITS(CB), .TIMEOUT(TMO)) dut (
    .sysclk_i(clk), .sysclk_rstn_i(rstn), .enable_i(enable_i), .use_pps_i(use_pps_i),
    .pps_i(pps_i), .period_i(period_i), .chan_en_i(chan_en_i), .scal_req_o(scal_req_o),
    .scal_chan_o(scal_chan_o), .scal_ack_i(scal_ack_i), .scal_dat_i(scal_dat_i),
    .buf_we_o(buf_we_o), .buf_addr_o(buf_addr_o), .buf_dat_o(buf_dat_o), .bank_o(bank_o),
    .done_o(done_o), .busy_o(busy_o), .overrun_o(overrun_o), .timeout_o(timeout_o),
    .clr_flags_i(clr_flags_i)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic cmp(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Responder tables: ack arrives in WAIT cycle k_tab[c] (never if > TMO)
  int          k_tab [NCH];
  logic [15:0] v_tab [NCH];

  // Bank responder, driven just after each rising edge
  int age = 0;
  always @(posedge clk) begin
    #2;
    if (scal_req_o) age = age + 1; else age = 0;
    if (scal_req_o && age == k_tab[scal_chan_o] + 1) begin
      scal_ack_i = 1'b1;
      scal_dat_i = v_tab[scal_chan_o];
    end else begin
      scal_ack_i = (!scal_req_o || age == 1) && ($urandom_range(0, 7) == 0);
      scal_dat_i = 16'($urandom);
    end
  end

  // Reference model: a started set expands into its list of expected cycles
  typedef struct {
    bit busy; bit req; int chan; bit we; int addr; int dat; bit done; bit tmo;
  } rec_t;

  rec_t        exp_q[$];
  bit          mdl_bank = 0, mdl_ovr = 0, mdl_tmo = 0, tick_prev = 0;
  logic [31:0] pcnt = '0;

  function automatic void build_set();
    rec_t r;
    int   w;
    int   d;
    for (int c = 0; c < NCH; c++) begin
      r = '{default:0};
      r.busy = 1; r.chan = c;
      if (chan_en_i[c]) begin
        r.req = 1;
        exp_q.push_back(r);
        w = (k_tab[c] <= TMO) ? k_tab[c] : TMO;
        for (int j = 1; j <= w; j++) begin
          r.tmo = (j == TMO) && (k_tab[c] > TMO);
          exp_q.push_back(r);
        end
        r.req = 0; r.tmo = 0;
        d = (k_tab[c] <= TMO) ? int'(v_tab[c]) : 32'hFFFF;
      end else begin
        exp_q.push_back(r);
        d = 0;
      end
      r.we = 1; r.addr = (mdl_bank ? 0 : NCH) + c; r.dat = d;
      exp_q.push_back(r);
    end
    r = '{default:0};
    r.busy = 1; r.done = 1;
    exp_q.push_back(r);
  endfunction

  // Monitors feeding the literal checks
  int  ram [2*NCH];
  int  done_cnt = 0, busy_cnt = 0, req_rise = 0, max_run = 0, run = 0;
  bit  req_prev = 0;

  // Compare process: every cycle against the model, then advance the model
  always @(negedge clk) begin
    rec_t e;
    bit   ovs;
    e = '{default:0};
    if (!rstn) begin
      exp_q.delete();
      mdl_bank = 0; mdl_ovr = 0; mdl_tmo = 0; tick_prev = 0; pcnt = '0;
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
    end
    cmp("busy", busy_o, e.busy);
    cmp("req", scal_req_o, e.req);
    if (e.req) cmp("chan", scal_chan_o, e.chan);
    cmp("we", buf_we_o, e.we);
    if (e.we) begin
      cmp("addr", buf_addr_o, e.addr);
      cmp("dat", buf_dat_o, e.dat);
    end
    cmp("done", done_o, e.done);
    cmp("bank", bank_o, mdl_bank);
    cmp("overrun", overrun_o, mdl_ovr);
    cmp("timeout", timeout_o, mdl_tmo);
    if (rstn) begin
      ovs = 0;
      if (tick_prev) begin
        if (e.busy) ovs = 1;
        else if (enable_i) build_set();
      end
      if (ovs) mdl_ovr = 1; else if (clr_flags_i) mdl_ovr = 0;
      if (e.tmo) mdl_tmo = 1; else if (clr_flags_i) mdl_tmo = 0;
      if (e.done) mdl_bank = ~mdl_bank;
      tick_prev = use_pps_i ? pps_i : ((period_i != 0) && (pcnt == period_i - 1));
      if (period_i == 0 || pcnt == period_i - 1) pcnt = '0; else pcnt = pcnt + 1;
    end
    if (buf_we_o) ram[buf_addr_o] = int'(buf_dat_o);
    if (done_o) done_cnt++;
    if (busy_o) busy_cnt++;
    if (scal_req_o && !req_prev) req_rise++;
    run = scal_req_o ? run + 1 : 0;
    if (run > max_run) max_run = run;
    req_prev = scal_req_o;
  end

  task automatic tick_pps();
    @(posedge clk); #1 pps_i = 1'b1;
    @(posedge clk); #1 pps_i = 1'b0;
  endtask

  task automatic wait_idle(input int maxc);
    int n = 0;
    repeat (2) @(posedge clk);
    #1;
    while (busy_o && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    cmp("idle_wait", busy_o, 0);
  endtask

  task automatic wait_req_chan(input int c, input int maxc);
    int n = 0;
    while (!(scal_req_o && scal_chan_o == 2'(c)) && n < maxc) begin
      @(posedge clk); #1;
      n++;
    end
    cmp("wait_req_chan", int'(scal_req_o && scal_chan_o == 2'(c)), 1);
  endtask

  task automatic set_tables(input int k, input int v0, input int v1, input int v2, input int v3);
    for (int c = 0; c < NCH; c++) k_tab[c] = k;
    v_tab[0] = 16'(v0); v_tab[1] = 16'(v1); v_tab[2] = 16'(v2); v_tab[3] = 16'(v3);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r0, d0;
    set_tables(1, 0, 0, 0, 0);
    for (int a = 0; a < 2*NCH; a++) ram[a] = -1;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk); #1;
    cmp("rst_bank", bank_o, 0);
    cmp("rst_busy", busy_o, 0);
    cmp("rst_req", scal_req_o, 0);
    cmp("rst_flags", {overrun_o, timeout_o}, 0);
    enable_i = 1'b1;

    // All enabled, ack in first WAIT cycle
    chan_en_i = 4'hF; set_tables(1, 10, 20, 30, 40); done_cnt = 0;
    tick_pps(); wait_idle(200);
    cmp("t1_ram4", ram[4], 10); cmp("t1_ram5", ram[5], 20);
    cmp("t1_ram6", ram[6], 30); cmp("t1_ram7", ram[7], 40);
    cmp("t1_done", done_cnt, 1); cmp("t1_bank", bank_o, 1);

    // Channels 0 and 2 only
    chan_en_i = 4'b0101; set_tables(1, 7, 7, 7, 7); busy_cnt = 0; req_rise = 0;
    tick_pps(); wait_idle(200);
    cmp("t2_ram0", ram[0], 7); cmp("t2_ram1", ram[1], 0);
    cmp("t2_ram2", ram[2], 7); cmp("t2_ram3", ram[3], 0);
    cmp("t2_cycles", busy_cnt, 11); cmp("t2_reqs", req_rise, 2);

    // Channel 1 never answers
    chan_en_i = 4'hF; set_tables(1, 1, 2, 3, 4); k_tab[1] = 100; max_run = 0;
    tick_pps(); wait_idle(300);
    cmp("t3_reqlen", max_run, 1 + TMO);
    cmp("t3_ram4", ram[4], 1); cmp("t3_ram5", ram[5], 32'hFFFF);
    cmp("t3_tmo", timeout_o, 1);
    clr_flags_i = 1'b1; @(posedge clk); #1 clr_flags_i = 1'b0;
    cmp("t3_tmo_clr", timeout_o, 0);

    // Internal period much shorter than a slow set
    set_tables(10, 5, 6, 7, 8);
    period_i = 32'd5; use_pps_i = 1'b0;
    repeat (120) @(posedge clk);
    #1;
    cmp("t4_ovr", overrun_o, 1);
    period_i = 32'd0; wait_idle(400);
    clr_flags_i = 1'b1; @(posedge clk); #1 clr_flags_i = 1'b0;
    cmp("t4_ovr_clr", overrun_o, 0);
    r0 = req_rise;
    repeat (60) @(posedge clk);
    #1;
    cmp("t4_period0", req_rise - r0, 0);
    use_pps_i = 1'b1;

    // Reset during WAIT of channel 2
    set_tables(10, 1, 2, 3, 4);
    tick_pps(); wait_req_chan(2, 200);
    @(posedge clk); #1 rstn = 1'b0;
    #1;
    cmp("t5_req", scal_req_o, 0); cmp("t5_busy", busy_o, 0);
    cmp("t5_we", buf_we_o, 0); cmp("t5_bank", bank_o, 0);
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    tick_pps(); wait_req_chan(0, 20);
    cmp("t5_restart_chan", scal_chan_o, 0);
    wait_idle(300);

    // Enable dropped mid-set
    set_tables(1, 9, 8, 7, 6); d0 = done_cnt;
    tick_pps(); wait_req_chan(1, 50);
    enable_i = 1'b0;
    wait_idle(200);
    cmp("t6_done", done_cnt - d0, 1);
    r0 = req_rise;
    tick_pps(); repeat (10) @(posedge clk);
    tick_pps(); repeat (10) @(posedge clk);
    #1;
    cmp("t6_noreq", req_rise - r0, 0);

    // Randomized windows
    for (int it = 0; it < 24; it++) begin
      chan_en_i = 4'($urandom);
      for (int c = 0; c < NCH; c++) begin
        k_tab[c] = $urandom_range(1, 20);
        v_tab[c] = 16'($urandom);
      end
      enable_i = 1'b1;
      if ($urandom_range(0, 1) == 0) begin
        use_pps_i = 1'b0; period_i = 32'($urandom_range(2, 70));
      end else begin
        use_pps_i = 1'b1;
      end
      for (int cy = 0; cy < 300; cy++) begin
        @(posedge clk); #1;
        pps_i = use_pps_i && ($urandom_range(0, 39) == 0);
        if ($urandom_range(0, 59) == 0) enable_i = ~enable_i;
        clr_flags_i = ($urandom_range(0, 29) == 0);
      end
      @(posedge clk); #1;
      pps_i = 1'b0; clr_flags_i = 1'b0; period_i = '0; use_pps_i = 1'b1;
      wait_idle(1000);
      repeat (2) @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
